// File: rtl/decode_onehot_timed.sv
// -----------------------------------------------------------------------------
// decode_onehot_timed
//
// Registered binary-to-one-hot decoder with a valid/ready input handshake.
// An accepted code is either held for HOLD_CYCLES cycles (pulse mode) or kept
// until the next accept replaces it (latch mode). The decoder is meant to
// drive chip-selects, mux selects and per-channel load strobes.
//
// Optional feature macro: DECODE_RANGE_CHECK_EN
//   defined   : an out-of-range code (iData >= OUT_N) raises oErr for one
//               cycle and keeps oDecode/oValid low for that transfer's window.
//   undefined : no check logic; oErr is tied low and an out-of-range code
//               gives oDecode=0 with oValid=1.
//
// Parameters
//   IN_W         width of the binary code
//   OUT_N        number of one-hot outputs (2 <= OUT_N <= 2**IN_W)
//   HOLD_CYCLES  pulse-mode output width in cycles (>= 1)
//
// Ports
//   iClk     in   1      clock, rising edge
//   iRst_n   in   1      asynchronous reset, active low
//   iEnable  in   1      low = clear on next edge, no accepts
//   iValid   in   1      iData/iMode valid
//   oReady   out  1      block can accept this cycle (combinational)
//   iData    in   IN_W   binary code to decode
//   iMode    in   1      0 = pulse, 1 = latch; sampled on accept
//   oDecode  out  OUT_N  registered one-hot output
//   oValid   out  1      oDecode carries a decoded word
//   oErr     out  1      out-of-range strobe (range check build only)
// -----------------------------------------------------------------------------
module decode_onehot_timed #(
  parameter int IN_W        = 3,
  parameter int OUT_N       = 8,
  parameter int HOLD_CYCLES = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEnable,
  input  logic             iValid,
  output logic             oReady,
  input  logic [IN_W-1:0]  iData,
  input  logic             iMode,
  output logic [OUT_N-1:0] oDecode,
  output logic             oValid,
  output logic             oErr
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    LATCH = 2'd2
  } stateT;

  stateT            stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;
  logic [OUT_N-1:0] decodeReg, decodeNext;
  logic             validReg, validNext;
  logic [OUT_N-1:0] codeOneHot;
  logic             accept;

  // Straight compare per output bit; an out-of-range code matches no bit,
  // so codeOneHot is all-zero for it without any extra masking.
  generate
    for (genvar gi = 0; gi < OUT_N; gi++) begin : gDecode
      assign codeOneHot[gi] = (iData == IN_W'(gi));
    end
  endgenerate

  // Only the final hold cycle may accept, which lets HOLD_CYCLES=1 strobe at
  // full rate. iRst_n is folded in so oReady is low during reset.
  assign oReady = iRst_n & iEnable & ((stateReg != HOLD) | (cntReg == '0));
  assign accept = iValid & oReady;

`ifdef DECODE_RANGE_CHECK_EN
  logic inRange;
  logic errReg;

  assign inRange = (32'(iData) < 32'(OUT_N));

  // accept already implies iEnable, so a disable never raises oErr.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      errReg <= 1'b0;
    end else begin
      errReg <= accept & ~inRange;
    end
  end

  assign oErr = errReg;
`else
  assign oErr = 1'b0;
`endif

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    decodeNext = decodeReg;
    validNext  = validReg;

    if (!iEnable) begin
      // Disable aborts whatever is in flight.
      stateNext  = IDLE;
      cntNext    = '0;
      decodeNext = '0;
      validNext  = 1'b0;
    end else if (accept) begin
      // New code takes over on this edge from any state: no zero gap.
      stateNext  = iMode ? LATCH : HOLD;
      cntNext    = iMode ? '0 : CNT_LOAD;
      decodeNext = codeOneHot;
`ifdef DECODE_RANGE_CHECK_EN
      validNext  = inRange;
`else
      validNext  = 1'b1;
`endif
    end else begin
      case (stateReg)
        HOLD: begin
          if (cntReg == '0) begin
            stateNext  = IDLE;
            decodeNext = '0;
            validNext  = 1'b0;
          end else begin
            cntNext = cntReg - CNT_W'(1);
          end
        end
        LATCH: begin
          // Output held until replaced or disabled.
        end
        default: begin
          stateNext  = IDLE;
          cntNext    = '0;
          decodeNext = '0;
          validNext  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      decodeReg <= '0;
      validReg  <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      decodeReg <= decodeNext;
      validReg  <= validNext;
    end
  end

  assign oDecode = decodeReg;
  assign oValid  = validReg;

endmodule
